// File: rtl/fifo_stream_reader_if.sv
// FIFO access bundle shared by FIFO producers and consumers.
interface fifo_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  ren;
   logic                  wen;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  empty;
   logic                  full;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output ren, wen, wdata, input empty, full, rdata);
   modport slave  (input ren, wen, wdata, output empty, full, rdata);
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a programmed burst from a fixed-latency FIFO and streams it out over valid/ready.
// Optional starvation timeout: define FIFO_RD_TIMEOUT_EN.
module fifo_stream_reader #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned RD_LAT      = 2,
   parameter int unsigned LEN_W       = 16,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   fifo_if.master                ifp_ff,
   input  logic                  start,
   input  logic [LEN_W-1:0]      burst_len,
   output logic                  busy,
   output logic                  done,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  err
);

   localparam int unsigned DEPTH = RD_LAT + 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                state, state_nxt;
   logic [LEN_W-1:0]      len, issued, delivered;
   logic [RD_LAT-1:0]     pop_sr;
   logic [CNT_W-1:0]      inflight, skid_cnt;
   logic [DATA_WIDTH-1:0] skid_mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [OCC_W-1:0]      occ_c;
   logic                  start_take_c, xfer_c, cap_c, credit_c, pop_c;
   logic                  starve_hit_c, drain_last_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A word leaving the skid this cycle frees its slot, so one-per-cycle streaming is kept.
   assign start_take_c = (state == IDLE) && start;
   assign m_valid      = (skid_cnt != '0);
   assign xfer_c       = m_valid && m_ready;
   assign cap_c        = pop_sr[RD_LAT-1];
   assign occ_c        = OCC_W'(inflight) + OCC_W'(skid_cnt) - OCC_W'(xfer_c);
   assign credit_c     = (state == RUN) && (issued < len) && (occ_c < OCC_W'(DEPTH));
   assign pop_c        = credit_c && !ifp_ff.empty;

   assign ifp_ff.ren   = pop_c;
   assign ifp_ff.wen   = 1'b0;
   assign ifp_ff.wdata = '0;

   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign m_data = skid_mem[rd_ptr];
   assign m_last = m_valid && (((delivered + LEN_W'(1)) == len) || drain_last_c);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (burst_len == '0) ? DONE : RUN;
         RUN:     if ((pop_c && ((issued + LEN_W'(1)) == len)) || starve_hit_c) state_nxt = FLUSH;
         FLUSH:   if ((inflight == '0) && (skid_cnt == '0)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Burst counters, pop-flag pipeline and skid buffer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         len       <= '0;
         issued    <= '0;
         delivered <= '0;
         pop_sr    <= '0;
         inflight  <= '0;
         skid_cnt  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) skid_mem[i] <= '0;
      end else begin
         if (start_take_c) begin
            len       <= burst_len;
            issued    <= '0;
            delivered <= '0;
         end else begin
            if (pop_c)  issued    <= issued + LEN_W'(1);
            if (xfer_c) delivered <= delivered + LEN_W'(1);
         end
         pop_sr[0] <= pop_c;
         for (int i = 1; i < int'(RD_LAT); i++) pop_sr[i] <= pop_sr[i-1];
         inflight <= inflight + CNT_W'(pop_c) - CNT_W'(cap_c);
         skid_cnt <= skid_cnt + CNT_W'(cap_c) - CNT_W'(xfer_c);
         if (cap_c) begin
            skid_mem[wr_ptr] <= ifp_ff.rdata;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (xfer_c) rd_ptr <= ptr_inc(rd_ptr);
      end
   end

`ifdef FIFO_RD_TIMEOUT_EN
   localparam int unsigned STARVE_W = $clog2(TIMEOUT_CYC + 1);

   logic [STARVE_W-1:0] starve_cnt;
   logic                err_q;
   logic                blocked_c;

   // Starvation means every credit condition holds except FIFO occupancy.
   assign blocked_c    = credit_c && ifp_ff.empty;
   assign starve_hit_c = blocked_c && (starve_cnt == STARVE_W'(TIMEOUT_CYC - 1));
   assign drain_last_c = err_q && (state == FLUSH) && (inflight == '0) && (skid_cnt == CNT_W'(1));
   assign err          = err_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
         err_q      <= 1'b0;
      end else if (start_take_c) begin
         starve_cnt <= '0;
         err_q      <= 1'b0;
      end else if (pop_c || (state != RUN)) begin
         starve_cnt <= '0;
      end else if (starve_hit_c) begin
         starve_cnt <= '0;
         err_q      <= 1'b1;
      end else if (blocked_c) begin
         starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end
`else
   assign starve_hit_c = 1'b0;
   assign drain_last_c = 1'b0;
   assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural fixed-latency FIFO model.
module tb_fifo_stream_reader;
   localparam int unsigned DW = 32;
   localparam int unsigned RL = 2;
   localparam int unsigned LW = 16;
`ifdef FIFO_RD_TIMEOUT_EN
   localparam int unsigned TO = 16;
`else
   localparam int unsigned TO = 1024;
`endif

   typedef struct {
      int unsigned pre;
      int unsigned len;
      logic [DW-1:0] base;
      int unsigned rdy_mode;
      int unsigned exp_n;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, m_ready;
   logic [LW-1:0] burst_len;
   logic          busy, done, m_valid, m_last, err;
   logic [DW-1:0] m_data;

   fifo_if #(.DATA_WIDTH(DW)) ff ();

   fifo_stream_reader #(.DATA_WIDTH(DW), .RD_LAT(RL), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .ifp_ff(ff), .start(start), .burst_len(burst_len),
      .busy(busy), .done(done), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last), .err(err)
   );

   // FIFO model: pop at an edge, data appears on rdata RL-1 edges later so the DUT samples it RL edges after the pop.
   logic [DW-1:0] fmem [256];
   int unsigned   wr_idx = 0;
   int unsigned   rd_idx = 0;
   logic          fifo_clr = 1'b0;
   logic [DW-1:0] pipe [RL];

   assign ff.empty = (wr_idx == rd_idx);
   assign ff.full  = 1'b0;
   assign ff.rdata = pipe[RL-1];

   always @(posedge clk) begin
      if (fifo_clr) rd_idx <= wr_idx;
      else if (ff.ren && !ff.empty) rd_idx <= rd_idx + 1;
      pipe[0] <= (ff.ren && !ff.empty) ? fmem[rd_idx % 256] : '0;
      for (int i = 1; i < int'(RL); i++) pipe[i] <= pipe[i-1];
   end

   // Output monitor and protocol watchers.
   int unsigned   cyc = 0, rx_n = 0, pop_n = 0, hold_viol = 0, ren_empty_viol = 0;
   logic [DW-1:0] rx_data [1024];
   logic          rx_last [1024];
   int unsigned   rx_cyc  [1024];
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ff.ren && !ff.empty) pop_n <= pop_n + 1;
      if (ff.ren && ff.empty) ren_empty_viol <= ren_empty_viol + 1;
      if (rst && m_valid && m_ready) begin
         rx_data[rx_n % 1024] <= m_data;
         rx_last[rx_n % 1024] <= m_last;
         rx_cyc[rx_n % 1024]  <= cyc;
         rx_n <= rx_n + 1;
      end
      if (rst && prev_stall && m_valid && ((m_data != prev_data) || (m_last != prev_last)))
         hold_viol <= hold_viol + 1;
      prev_stall <= rst && m_valid && !m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
   end

   int checks = 0, failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] v);
      fmem[wr_idx % 256] = v;
      wr_idx = wr_idx + 1;
   endtask

   task automatic clear_fifo();
      @(negedge clk) fifo_clr = 1'b1;
      @(negedge clk) fifo_clr = 1'b0;
   endtask

   task automatic pulse_start(input int unsigned len);
      burst_len = LW'(len);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   function automatic logic rdy_of(input int unsigned mode, input int unsigned k);
      case (mode)
         0:       return 1'b1;
         1:       return (k % 2) == 0;
         2:       return (k < 20) ? ((k % 2) == 0) : (k >= 30);
         default: return ((k * 7) % 5) != 0;
      endcase
   endfunction

   // Checks that rx[base..base+n-1] holds first+i with m_last only on the final word.
   task automatic chk_words(input string tag, input int unsigned base, input int unsigned n,
                            input logic [DW-1:0] first, input int unsigned got);
      int unsigned mism = 0, lasts = 0, last_pos = 0;
      chk({tag, "_count"}, got, n);
      for (int i = 0; i < int'(n); i++) begin
         if (rx_data[(base + i) % 1024] != first + DW'(i)) mism++;
         if (rx_last[(base + i) % 1024]) begin lasts++; last_pos = i; end
      end
      chk({tag, "_data_mism"}, mism, 0);
      chk({tag, "_last_cnt"}, lasts, 1);
      chk({tag, "_last_pos"}, last_pos, n - 1);
   endtask

   task automatic run_burst(input vec_t v, input int idx);
      int unsigned rx_base, pop_base, k, dones;
      string tag;
      tag = $sformatf("v%0d", idx);
      clear_fifo();
      for (int i = 0; i < int'(v.pre); i++) push(v.base + DW'(i));
      rx_base  = rx_n;
      pop_base = pop_n;
      m_ready  = rdy_of(v.rdy_mode, 0);
      pulse_start(v.len);
      chk({tag, "_busy_after_start"}, busy, 1);
      k = 0; dones = 0;
      while (k < 600 && dones == 0) begin
         m_ready = rdy_of(v.rdy_mode, k);
         @(negedge clk);
         if (done) dones++;
         if (v.rdy_mode == 2 && k == 29)
            chk({tag, "_credit_stop"}, (pop_n - pop_base) - (rx_n - rx_base), RL + 1);
         k++;
      end
      chk({tag, "_done_seen"}, dones, 1);
      chk_words(tag, rx_base, v.exp_n, v.base, rx_n - rx_base);
      if (v.rdy_mode == 0)
         chk({tag, "_back_to_back"}, rx_cyc[(rx_base + v.exp_n - 1) % 1024] - rx_cyc[rx_base % 1024], v.exp_n - 1);
      chk({tag, "_err"}, err, 0);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done, 0);
      chk({tag, "_busy_low"}, busy, 0);
      m_ready = 1'b1;
   endtask

   vec_t vecs [5];

   initial begin
      int unsigned rx_base, k, dones, seen_valid;
      vec_t v2;
      vecs[0] = '{pre: 8,  len: 8,  base: 32'h10,  rdy_mode: 0, exp_n: 8};
      vecs[1] = '{pre: 16, len: 16, base: 32'h100, rdy_mode: 2, exp_n: 16};
      vecs[2] = '{pre: 5,  len: 3,  base: 32'h200, rdy_mode: 1, exp_n: 3};
      vecs[3] = '{pre: 1,  len: 1,  base: 32'h300, rdy_mode: 0, exp_n: 1};
      vecs[4] = '{pre: 6,  len: 6,  base: 32'h400, rdy_mode: 3, exp_n: 6};

      rst = 1'b0; start = 1'b0; m_ready = 1'b1; burst_len = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_err", err, 0);
      chk("rst_ren", ff.ren, 0);
      chk("rst_wen", ff.wen, 0);
      chk("rst_wdata", ff.wdata, 0);
      rst = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_burst(vecs[i], i);

      // Zero-length burst completes without any output word.
      seen_valid = 0; dones = 0;
      pulse_start(0);
      for (int i = 0; i < 2; i++) begin
         if (m_valid) seen_valid++;
         if (done) dones++;
         @(negedge clk);
      end
      chk("zero_len_done", dones, 1);
      chk("zero_len_no_valid", seen_valid, 0);
      chk("zero_len_idle", busy, 0);

      // Second start while busy must not alter the running burst.
      clear_fifo();
      for (int i = 0; i < 8; i++) push(32'h700 + DW'(i));
      rx_base = rx_n;
      pulse_start(4);
      @(negedge clk);
      pulse_start(2);
      k = 0; dones = 0;
      while (k < 100 && dones == 0) begin @(negedge clk); if (done) dones++; k++; end
      chk("ign_start_done", dones, 1);
      chk_words("ign_start", rx_base, 4, 32'h700, rx_n - rx_base);

      // Starvation: stall in RUN until the FIFO is refilled.
      clear_fifo();
      for (int i = 0; i < 3; i++) push(32'h600 + DW'(i));
      rx_base = rx_n; dones = 0;
      pulse_start(5);
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (done) dones++; end
      chk("starve_busy", busy, 1);
      chk("starve_partial", rx_n - rx_base, 3);
      chk("starve_no_done", dones, 0);
      chk("starve_err", err, 0);
      push(32'h603); push(32'h604);
      k = 0;
      while (k < 100 && dones == 0) begin @(negedge clk); if (done) dones++; k++; end
      chk("starve_done", dones, 1);
      chk_words("starve", rx_base, 5, 32'h600, rx_n - rx_base);
      chk("starve_err_end", err, 0);

      // Reset during the 4th beat abandons the burst.
      clear_fifo();
      for (int i = 0; i < 8; i++) push(32'h800 + DW'(i));
      rx_base = rx_n;
      pulse_start(8);
      k = 0;
      while (k < 50 && !((rx_n - rx_base) == 3 && m_valid)) begin @(negedge clk); k++; end
      chk("midrst_reached_4th", rx_n - rx_base, 3);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ren", ff.ren, 0);
      v2 = '{pre: 2, len: 2, base: 32'h900, rdy_mode: 0, exp_n: 2};
      run_burst(v2, 9);

`ifdef FIFO_RD_TIMEOUT_EN
      // Timeout: two words held in the skid until the starvation limit fires.
      clear_fifo();
      push(32'hA00); push(32'hA01);
      rx_base = rx_n;
      m_ready = 1'b0;
      pulse_start(4);
      k = 0;
      while (k < 60 && !err) begin @(negedge clk); k++; end
      chk("to_err_set", err, 1);
      chk("to_err_window", (k >= 12 && k <= 24), 1);
      chk("to_nothing_sent", rx_n - rx_base, 0);
      m_ready = 1'b1;
      k = 0; dones = 0;
      while (k < 30 && dones == 0) begin @(negedge clk); if (done) dones++; k++; end
      chk("to_done", dones, 1);
      chk_words("to", rx_base, 2, 32'hA00, rx_n - rx_base);
      @(negedge clk);
      chk("to_err_held", err, 1);
`endif

      chk("hold_stable", hold_viol, 0);
      chk("ren_on_empty", ren_empty_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1);
   end
endmodule
